multi_clock_divider: RTL and testbench

Parametrised, multi-channel successor to the fixed single-output clock divider. Each of `CHANNELS` independent channels divides the system clock by a runtime-programmable divisor. Each channel produces a 50 % square `clk_out` and a one-cycle `tick` strobe. Sits between the board clock and slow consumers (display refresh, LED blink, debouncers, UART baud strobes), replacing per-consumer hard-coded dividers.

---
 rtl/multi_clock_divider_if.sv | 27 ++
 rtl/multi_clock_divider.sv | 93 +++++++++
 tb/tb_multi_clock_divider.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_clock_divider_if.sv
// Control/status bundle for multi_clock_divider: per-channel enables, divisor
// write port, sync pulse, and the divided clock, tick and pending outputs.
interface multi_clock_divider_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 32
);
  localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] en;
  logic                div_wr;
  logic [SelW-1:0]     div_sel;
  logic [WIDTH-1:0]    div_data;
  logic                sync;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] div_pending;

  modport master (
    output en, div_wr, div_sel, div_data, sync,
    input  clk_out, tick, div_pending
  );

  modport slave (
    input  en, div_wr, div_sel, div_data, sync,
    output clk_out, tick, div_pending
  );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider with glitch-free shadowed divisor updates.
// Optional channel phase alignment via the sync pulse when MULTI_CLKDIV_SYNC_EN is defined.
module multi_clock_divider #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input logic                  clk,
  input logic                  reset,
  multi_clock_divider_if.slave bus
);
  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    r_count      [CHANNELS];
  logic [WIDTH-1:0]    r_div_active [CHANNELS];
  logic [WIDTH-1:0]    r_div_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_clk_out;
  logic [CHANNELS-1:0] r_tick;

  logic [WIDTH-1:0]    w_count_d      [CHANNELS];
  logic [WIDTH-1:0]    w_div_active_d [CHANNELS];
  logic [WIDTH-1:0]    w_div_shadow_d [CHANNELS];
  logic [WIDTH-1:0]    w_div_eff      [CHANNELS];
  logic [CHANNELS-1:0] w_pending_d;
  logic [CHANNELS-1:0] w_clk_out_d;
  logic [CHANNELS-1:0] w_tick_d;
  logic [CHANNELS-1:0] w_term;
  logic [CHANNELS-1:0] w_apply;
  logic [CHANNELS-1:0] w_wr_hit;
  logic                w_sync;

`ifdef MULTI_CLKDIV_SYNC_EN
  assign w_sync = bus.sync;
`else
  logic unused_sync;
  assign unused_sync = bus.sync;
  assign w_sync      = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // A programmed divisor of 0 behaves as divide-by-1.
      w_div_eff[i] = (r_div_active[i] == '0) ? WIDTH'(1) : r_div_active[i];
      w_term[i]    = bus.en[i] && (r_count[i] == w_div_eff[i] - WIDTH'(1));
      w_wr_hit[i]  = bus.div_wr && (int'(bus.div_sel) == i);
      w_apply[i]   = w_term[i] || !bus.en[i] || w_sync;

      w_count_d[i]   = r_count[i] + WIDTH'(1);
      w_tick_d[i]    = 1'b0;
      w_clk_out_d[i] = r_clk_out[i];
      if (w_sync || !bus.en[i]) begin
        w_count_d[i]   = '0;
        w_clk_out_d[i] = 1'b0;
      end else if (w_term[i]) begin
        w_count_d[i]   = '0;
        w_tick_d[i]    = 1'b1;
        w_clk_out_d[i] = ~r_clk_out[i];
      end

      // Apply uses the pre-write shadow, so a coincident write stays pending.
      w_div_active_d[i] = w_apply[i] ? r_div_shadow[i] : r_div_active[i];
      w_div_shadow_d[i] = w_wr_hit[i] ? bus.div_data : r_div_shadow[i];
      w_pending_d[i]    = w_wr_hit[i] | (r_pending[i] & ~w_apply[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_count[i]      <= '0;
        r_div_active[i] <= DefDiv;
        r_div_shadow[i] <= DefDiv;
      end
      r_pending <= '0;
      r_clk_out <= '0;
      r_tick    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_count[i]      <= w_count_d[i];
        r_div_active[i] <= w_div_active_d[i];
        r_div_shadow[i] <= w_div_shadow_d[i];
      end
      r_pending <= w_pending_d;
      r_clk_out <= w_clk_out_d;
      r_tick    <= w_tick_d;
    end
  end

  assign bus.clk_out     = r_clk_out;
  assign bus.tick        = r_tick;
  assign bus.div_pending = r_pending;
endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed scenarios with literal
// expectations plus randomized traffic against a period-timestamp reference model.
module tb_multi_clock_divider;
  localparam int unsigned CH  = 5;
  localparam int unsigned W   = 8;
  localparam int unsigned DEF = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  multi_clock_divider_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  multi_clock_divider #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each channel remembers the edge number at which its current
  // period began; a tick is due exactly D enabled edges later.
  int unsigned      m_edge;
  int unsigned      m_start  [CH];
  logic [W-1:0]     m_active [CH];
  logic [W-1:0]     m_shadow [CH];
  logic [CH-1:0]    m_clk;
  logic [CH-1:0]    m_tick;
  logic [CH-1:0]    m_pend;
  logic             m_sync;
  int unsigned      m_d;
  logic             m_apply;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_start[i]  = m_edge;
        m_active[i] = W'(DEF);
        m_shadow[i] = W'(DEF);
      end
      m_clk  = '0;
      m_tick = '0;
      m_pend = '0;
    end else begin
      m_edge++;
`ifdef MULTI_CLKDIV_SYNC_EN
      m_sync = bus.sync;
`else
      m_sync = 1'b0;
`endif
      for (int i = 0; i < CH; i++) begin
        m_d     = (m_active[i] == 0) ? 1 : int'(m_active[i]);
        m_apply = 1'b0;
        if (m_sync || !bus.en[i]) begin
          m_start[i] = m_edge;
          m_clk[i]   = 1'b0;
          m_tick[i]  = 1'b0;
          m_apply    = 1'b1;
        end else if (m_edge - m_start[i] == m_d) begin
          m_start[i] = m_edge;
          m_tick[i]  = 1'b1;
          m_clk[i]   = ~m_clk[i];
          m_apply    = 1'b1;
        end else begin
          m_tick[i] = 1'b0;
        end
        if (m_apply) begin
          m_active[i] = m_shadow[i];
          m_pend[i]   = 1'b0;
        end
        if (bus.div_wr && int'(bus.div_sel) == i) begin
          m_shadow[i] = bus.div_data;
          m_pend[i]   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_clk_out", 32'(bus.clk_out), 32'(m_clk));
      check("model_tick", 32'(bus.tick), 32'(m_tick));
      check("model_pending", 32'(bus.div_pending), 32'(m_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_div(input int sel, input int data);
    bus.div_wr   = 1'b1;
    bus.div_sel  = 3'(sel);
    bus.div_data = W'(data);
    step();
    bus.div_wr = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    m_edge       = 0;
    reset        = 1'b1;
    bus.en       = '0;
    bus.div_wr   = 1'b0;
    bus.div_sel  = '0;
    bus.div_data = '0;
    bus.sync     = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_clk_out", 32'(bus.clk_out), 0);
    check("reset_tick", 32'(bus.tick), 0);
    check("reset_pending", 32'(bus.div_pending), 0);

    // Default divisor 4 on ch0: ticks on edges 4, 8, 12.
    bus.en = 5'b00001;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("ch0_tick", 32'(bus.tick[0]), 32'(k % 4 == 0));
      check("ch0_clk_out", 32'(bus.clk_out[0]), 32'((k / 4) % 2));
    end
    check("ch0_pending", 32'(bus.div_pending), 0);
    bus.en = '0;
    step();

    // Ch1 at D=5, shrink to 2 mid-period.
    write_div(1, 5);
    step();
    check("ch1_applied_disabled", 32'(bus.div_pending[1]), 0);
    bus.en = 5'b00010;
    step();
    write_div(1, 2);
    check("ch1_pending_set", 32'(bus.div_pending[1]), 1);
    step();
    step();
    check("ch1_pending_hold", 32'(bus.div_pending[1]), 1);
    check("ch1_no_early_tick", 32'(bus.tick[1]), 0);
    step();
    check("ch1_tick5", 32'(bus.tick[1]), 1);
    check("ch1_pending_clear", 32'(bus.div_pending[1]), 0);
    check("ch1_clk_high", 32'(bus.clk_out[1]), 1);
    step();
    check("ch1_gap", 32'(bus.tick[1]), 0);
    check("ch1_clk_hold", 32'(bus.clk_out[1]), 1);
    step();
    check("ch1_tick7", 32'(bus.tick[1]), 1);
    check("ch1_clk_low", 32'(bus.clk_out[1]), 0);
    bus.en = '0;
    step();

    // Divisor 0 on ch2 acts as divide-by-1.
    write_div(2, 0);
    step();
    bus.en = 5'b00100;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("ch2_tick", 32'(bus.tick[2]), 1);
      check("ch2_clk_out", 32'(bus.clk_out[2]), 32'(k % 2));
    end
    bus.en = '0;
    step();

    // Sync pulse with ch0 D=3, ch1 D=7 free-running for 5 edges.
    write_div(0, 3);
    write_div(1, 7);
    step();
    bus.en = 5'b00011;
    for (int k = 0; k < 5; k++) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
`ifdef MULTI_CLKDIV_SYNC_EN
    check("sync_clk_out", 32'(bus.clk_out[1:0]), 0);
    check("sync_tick", 32'(bus.tick[1:0]), 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check("sync_ch0_tick", 32'(bus.tick[0]), 32'(k % 3 == 0));
      check("sync_ch1_tick", 32'(bus.tick[1]), 32'(k == 7));
    end
`else
    check("nosync_ch0_tick", 32'(bus.tick[0]), 1);
    step();
    check("nosync_ch1_tick", 32'(bus.tick[1]), 1);
`endif
    bus.en = '0;
    step();

    // Ch3 D=20 dropped at count 10, then re-enabled.
    write_div(3, 20);
    step();
    bus.en = 5'b01000;
    for (int k = 0; k < 10; k++) step();
    bus.en = '0;
    step();
    check("ch3_off_clk", 32'(bus.clk_out[3]), 0);
    check("ch3_off_tick", 32'(bus.tick[3]), 0);
    bus.en = 5'b01000;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("ch3_reenable_tick", 32'(bus.tick[3]), 32'(k == 20));
    end
    bus.en = '0;
    step();

    // Invalid-channel write, then reset with a ch0 write pending.
    write_div(5, 9);
    check("invalid_sel_pending", 32'(bus.div_pending), 0);
    bus.en = 5'b00001;
    for (int k = 0; k < 4; k++) step();
    write_div(0, 6);
    check("pre_reset_pending", 32'(bus.div_pending[0]), 1);
    check("pre_reset_clk", 32'(bus.clk_out[0]), 1);
    reset = 1'b1;
    #1;
    check("async_reset_clk", 32'(bus.clk_out), 0);
    check("async_reset_tick", 32'(bus.tick), 0);
    check("async_reset_pending", 32'(bus.div_pending), 0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("post_reset_default", 32'(bus.tick[0]), 32'(k == 4));
    end

    // Randomized traffic, model checked on every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 7) == 0) bus.en[i] = ~bus.en[i];
      end
      bus.div_wr   = ($urandom_range(0, 3) == 0);
      bus.div_sel  = 3'($urandom_range(0, 7));
      bus.div_data = W'($urandom_range(0, 9));
      bus.sync     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    bus.div_wr = 1'b0;
    bus.sync   = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
